// File: rtl/ex_pipe_unit.sv
// MIPS execute stage: combinational logic/shift/arith ops plus a multi-cycle
// restoring unsigned divider (DIVU) that stalls upstream and writes HI/LO.
module ex_pipe_unit #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int SH_W   = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [2:0]        alusel_i,
   input  logic [7:0]        aluop_i,
   input  logic [WIDTH-1:0]  reg1_i,
   input  logic [WIDTH-1:0]  reg2_i,
   input  logic              wreg_i,
   input  logic [ADDR_W-1:0] waddr_i,
   output logic              wreg_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [WIDTH-1:0]  wdata_o,
   output logic              whilo_o,
   output logic [WIDTH-1:0]  hi_o,
   output logic [WIDTH-1:0]  lo_o,
   output logic              stall_req_o
);

   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUBU = 8'h23;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

   div_state_t        state_q, state_d;
   logic [WIDTH-1:0]  dvd_q, dvs_q, rem_q;
   logic [SH_W-1:0]   cnt_q;

   logic [SH_W-1:0]   shamt;
   logic [WIDTH-1:0]  logic_res, shift_res, arith_res, class_res;
   logic              slt_bit;

   logic [WIDTH:0]    rem_sh, diff;
   logic              q_bit;
   logic [WIDTH-1:0]  rem_step;

   logic              accept, stall_c, whilo_c;
   logic [WIDTH-1:0]  hi_c, lo_c;

   assign shamt   = reg1_i[SH_W-1:0];
   assign slt_bit = $signed(reg1_i) < $signed(reg2_i);

   always_comb begin
      logic_res = '0;
      shift_res = '0;
      arith_res = '0;
      case (aluop_i)
         OP_OR:   logic_res = reg1_i | reg2_i;
         OP_AND:  logic_res = reg1_i & reg2_i;
         OP_XOR:  logic_res = reg1_i ^ reg2_i;
         OP_NOR:  logic_res = ~(reg1_i | reg2_i);
         OP_SLL:  shift_res = reg2_i << shamt;
         OP_SRL:  shift_res = reg2_i >> shamt;
         OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> shamt);
         OP_ADDU: arith_res = reg1_i + reg2_i;
         OP_SUBU: arith_res = reg1_i - reg2_i;
         OP_SLT:  arith_res = {{(WIDTH-1){1'b0}}, slt_bit};
         default: ;
      endcase
   end

   always_comb begin
      case (alusel_i)
         3'd1:    class_res = logic_res;
         3'd2:    class_res = shift_res;
         3'd4:    class_res = arith_res;
         default: class_res = '0;
      endcase
   end

   // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
   assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
   assign diff     = rem_sh - {1'b0, dvs_q};
   assign q_bit    = ~diff[WIDTH];
   assign rem_step = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // stall_req_o asks upstream to hold the EX inputs unchanged for as long as it is high.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      stall_c = 1'b0;
      whilo_c = 1'b0;
      hi_c    = '0;
      lo_c    = '0;
      case (state_q)
         S_IDLE: begin
            if (valid_i && (aluop_i == OP_DIVU) && !flush_i) begin
               accept = 1'b1;
               if (reg2_i == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  stall_c = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               stall_c = 1'b1;
               if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!flush_i) begin
               whilo_c = 1'b1;
               lo_c    = dvd_q;
               hi_c    = rem_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The dividend register doubles as the quotient register, filling from the LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
         dvs_q <= reg2_i;
         if (reg2_i == '0) begin
            dvd_q <= '1;
            rem_q <= reg1_i;
         end else begin
            dvd_q <= reg1_i;
            rem_q <= '0;
         end
      end else if ((state_q == S_RUN) && !flush_i) begin
         dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
         rem_q <= rem_step;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign wreg_o      = wreg_i & valid_i & ~rst;
   assign waddr_o     = rst ? '0 : waddr_i;
   assign wdata_o     = rst ? '0 : class_res;
   assign whilo_o     = whilo_c & ~rst;
   assign hi_o        = rst ? '0 : hi_c;
   assign lo_o        = rst ? '0 : lo_c;
   assign stall_req_o = stall_c & ~rst;

endmodule

// File: doc/ex_pipe_unit.md
# ex_pipe_unit

Parametrised execute stage for the MIPS pipeline, sitting between the ID/EX and EX/MEM pipeline registers.
- Single-cycle ops (logic, shift, add/sub, compare) are combinational.
- Unsigned divide (DIVU) is a restoring divider producing one quotient bit per cycle. During the division it raises a stall request and finally writes HI/LO.

## Interface
Parameters:
- WIDTH, 32, datapath width (power of two, ≥8)
- ADDR_W, 5, register address width
- SH_W, $clog2(WIDTH), shift-amount width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  instruction present in EX
- flush_i  in  1  kill current instruction (abort divide)
- alusel_i  in  3  result class: 0 none, 1 LOGIC, 2 SHIFT, 4 ARITH
- aluop_i  in  8  operation code (list below)
- reg1_i  in  WIDTH  operand 1 (rs; shift amount for shifts)
- reg2_i  in  WIDTH  operand 2 (rt)
- wreg_i  in  1  GPR write enable from ID
- waddr_i  in  ADDR_W  GPR destination
- wreg_o  out  1  GPR write enable to EX/MEM
- waddr_o  out  ADDR_W  GPR destination
- wdata_o  out  WIDTH  GPR write data
- whilo_o  out  1  HI/LO write strobe (one cycle)
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient
- stall_req_o  out  1  hold upstream stages

## Operation
Op codes:
- 0x25 OR
- 0x24 AND
- 0x26 XOR
- 0x27 NOR
- 0x7C SLL
- 0x02 SRL
- 0x03 SRA
- 0x21 ADDU
- 0x23 SUBU
- 0x2A SLT
- 0x1B DIVU
- Any other code yields a class result of 0.

Single-cycle ops:
- Shifts: reg2_i shifted by reg1_i[SH_W-1:0]. SRA replicates reg2_i[WIDTH-1].
- ADDU/SUBU: modulo 2^WIDTH, no overflow trap.
- SLT: signed compare, result 1 or 0, zero-extended.
- wdata_o selects the class result by alusel_i. Unknown alusel_i gives wdata_o = 0.
- wreg_o = wreg_i & valid_i. waddr_o = waddr_i.

Divider FSM, states IDLE, RUN, DONE:
- IDLE:
  - valid_i & aluop_i==DIVU & !flush_i: latch dividend=reg1_i and divisor=reg2_i, clear count, go RUN.
  - Divisor 0: go DONE directly with quotient all-ones and remainder = dividend.
- RUN: one restoring step per cycle; count increments. After step WIDTH (count==WIDTH-1) go DONE.
- DONE:
  - whilo_o=1, lo_o=quotient, hi_o=remainder. Go IDLE.
  - DIVU produces no GPR write: wreg_o follows wreg_i, which ID drives 0 for DIVU.
- flush_i in RUN or DONE: go IDLE, no whilo_o pulse, stall_req_o low that cycle.
- Outside DONE, hi_o and lo_o are 0.

## Timing
- Reset: while rst=1, all outputs are 0. FSM→IDLE, count→0, internal dividend/divisor/partial remainder→0. Reset mid-divide aborts it with no HI/LO write.
- Single-cycle ops: zero latency, combinational from inputs. stall_req_o=0.
- stall_req_o is combinational:
  - 1 in IDLE when accepting a nonzero-divisor DIVU.
  - 1 throughout RUN.
  - 0 in DONE.
- Upstream holds EX inputs stable while stall_req_o=1.
- Nonzero-divisor DIVU: accept cycle 0, RUN cycles 1..WIDTH, DONE cycle WIDTH+1. Total WIDTH+2 cycles, i.e. 34 at WIDTH=32.
- Zero-divisor DIVU: DONE in cycle 1. stall_req_o is 0 in cycle 0 and cycle 1.
- In DONE the same DIVU is still presented by upstream. It is not re-accepted because the FSM is not in IDLE. The next instruction is accepted in the following cycle.
- Simultaneous flush_i and DIVU in IDLE: DIVU is not accepted.

## Test plan
- Logic/shift, WIDTH=32:
  - OR 0x0000F0F0|0x0F0F0000 → wdata_o=0x0F0FF0F0.
  - SRA, reg2=0x80000000, sh=4 → 0xF8000000.
  - SLL, sh=31, reg2=1 → 0x80000000.
- Arith:
  - ADDU 0xFFFFFFFF+1 → 0.
  - SUBU 0−1 → 0xFFFFFFFF.
  - SLT(-1, 1) → 1.
  - SLT(1, -1) → 0.
  - wreg_o=0 when valid_i=0.
- DIVU 100/7: stall_req_o high cycles 0..32, low in cycle 33. whilo_o pulses in cycle 33 with lo_o=14, hi_o=2.
- DIVU 0xFFFFFFFF/0: whilo_o in cycle 1 with lo_o=0xFFFFFFFF, hi_o=0xFFFFFFFF. stall_req_o never high.
- Abort:
  - flush_i at cycle 10 of DIVU → stall_req_o low in that cycle, no whilo_o.
  - A following OR executes normally.
  - Repeat with rst at cycle 10: all outputs 0, and a new DIVU 9/3 then gives lo=3, hi=0.
- Back-to-back DIVU 50/5 then 7/2: results lo=10 hi=0, then lo=3 hi=1. The second DIVU's accept cycle is the cycle after the first DONE.
